line_buffer_3x3: RTL and testbench
==================================

# line_buffer_3x3

Streaming 3x3 window generator for the median filter datapath. It sits directly upstream of the median sorter. It buffers the two previous image lines in two instances of the team's single-clock `bram` (write port plus registered read port). On every accepted pixel it emits the complete 3x3 neighbourhood whose bottom-right tap is that pixel. Only fully populated windows are emitted, so an H x W frame yields (H-2) x (W-2) windows.

## Interface
Parameters:
- `PIXEL_W`, 8: bits per pixel.
- `IMG_W`, 640: maximum line length in pixels. Line-buffer address width is `COL_W = $clog2(IMG_W)`.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `s_valid_i`  in  1: input pixel valid.
- `s_ready_o`  out  1: input ready; a pixel is accepted when `s_valid_i && s_ready_o`.
- `s_data_i`  in  `PIXEL_W`: pixel value.
- `s_sof_i`  in  1: qualifies an accepted pixel as the first pixel of a frame.
- `s_eol_i`  in  1: qualifies an accepted pixel as the last pixel of a line.
- `m_valid_o`  out  1: window valid.
- `m_ready_i`  in  1: downstream ready.
- `m_window_o`  out  `9*PIXEL_W`: window taps. Tap k occupies `[k*PIXEL_W +: PIXEL_W]`. k=0..2 is the top row (line y-2), left to right; k=3..5 is line y-1; k=6..8 is the current line; k=8 is the newest pixel.
- `m_eol_o`  out  1: window's bottom-right pixel ended its line.
- `err_o`  out  1: sticky line-format error (see Configuration).

## Operation
- Advance enable: `adv = !m_valid_o || m_ready_i`.
  - `s_ready_o = adv`. This is a combinational path from `m_ready_i` and is intentional.
  - When `adv` is 0, every register holds and both BRAM read addresses hold, so the BRAM outputs stay stable.
- Counters:
  - Column counter `col` (`COL_W` bits).
  - Row counter `row`, saturating at 2.
- Per accepted pixel:
  - If `s_sof_i` is set, the pixel is treated as being at col=0, row=0, and prior line data is ignored.
  - Line end occurs when `s_eol_i` is set, or implicitly when `col == IMG_W-1` (wrap). At line end, col returns to 0 and row increments (saturating). Otherwise col increments.
- Stage 1, accept cycle:
  - Both BRAMs are given read address `col`.
  - Pixel, col, row, eol and the window-qualify bit are registered.
  - Window-qualify bit: `row == 2 && col >= 2`.
- Stage 2, next advancing cycle:
  - BRAM data is available: lineA = y-1, lineB = y-2.
  - The window shifts left by one column. The new right column is {lineB, lineA, pixel}.
  - lineA BRAM writes the pixel at the stage-1 column.
  - lineB BRAM writes the old lineA value at the same column.
  - `m_valid_o` loads the qualify bit and `m_eol_o` loads the eol bit.
- Read/write address conflict: a write (stage 2, column c) and a read (stage 1, column c+1) never target the same address within a line. The column-0 read of a new line can coincide with the last write of the previous line only at a different address; no bypass is needed.
- The first two columns of each line shift into the window but never qualify.

## Timing
- Latency: a pixel accepted in cycle t with no stall produces `m_valid_o` in cycle t+2.
- Sustained throughput: 1 pixel/cycle while `m_ready_i` stays high.
- `m_window_o` and `m_eol_o` are stable while `m_valid_o && !m_ready_i`.
- Reset values: `m_valid_o`=0, `m_window_o`=0, `m_eol_o`=0, `err_o`=0, col=0, row=0, all pipeline registers 0.
  - `s_ready_o` is 1 after reset, because `m_valid_o`=0.
  - BRAM contents are not reset. Stale data is never emitted, because qualification requires row==2.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). The first window afterwards requires two complete lines plus three pixels.
- `s_sof_i` and `s_eol_i` on the same pixel: treated as a one-pixel line; row becomes 1.

## Configuration
- `LB_LINE_CHECK_EN` defined:
  - `err_o` is set, and held until the next accepted `s_sof_i` or reset, on either of these events:
    - an implicit wrap without `s_eol_i`;
    - `s_eol_i` accepted with col < 2 (line too short for a window).
  - Data flow is unaffected.
- `LB_LINE_CHECK_EN` undefined: `err_o` is tied to 0 and no check logic is built.

## Structure
- `median_filter_pkg` holds:
  - `WIN_DIM = 3` and `WIN_TAPS = 9`;
  - tap index constants: `TAP_CENTER = 4`, `TAP_NEWEST = 8`;
  - a `window_t` typedef (array of `WIN_TAPS` pixels), shared with the median sorter.
- Sub-module: `bram`, instantiated twice (lineA, lineB) with `DATA_W=PIXEL_W`, `ADDR_W=COL_W`. No other sub-module.

## Test plan
All scenarios use `IMG_W=4` and pixel = row*16+col.
- **Basic frame:** 4x4 frame, `m_ready_i`=1.
  - First window appears 2 cycles after pixel 0x22 is accepted: taps 00,01,02,10,11,12,20,21,22.
  - Exactly 4 windows in total; the last one has taps 11..33.
  - `m_eol_o`=1 on windows ending at 0x23 and 0x33.
- **Backpressure:** drop `m_ready_i` for 5 cycles while a window is valid.
  - `s_ready_o`=0 and `m_window_o` is frozen throughout.
  - The window sequence matches the scenario 1 output exactly.
- **Random valid/ready:** random gaps on `s_valid_i` and random `m_ready_i`. Output must match a scoreboard model, with no loss or duplication.
- **SOF mid-frame:** `s_sof_i` after 1.5 lines.
  - No window until two new lines plus three pixels.
  - No pre-SOF pixel ever appears in a tap.
- **Reset mid-frame:** `rst_n` low for 1 cycle during row 3.
  - `m_valid_o` drops to 0 immediately.
  - A fresh 4x4 frame then reproduces the scenario 1 output.
- **`LB_LINE_CHECK_EN`:**
  - `s_eol_i` at col 1 → `err_o`=1, held until the next SOF.
  - 8 pixels with no `s_eol_i` → implicit wrap: 2 lines are counted and `err_o`=1.
  - With the macro undefined, the same stimulus leaves `err_o`=0.

Source files
------------

// File: rtl/median_filter_pkg.sv
// Shared constants and types for the median filter datapath.
package median_filter_pkg;
  localparam int WIN_DIM     = 3;
  localparam int WIN_TAPS    = 9;
  localparam int TAP_CENTER  = 4;
  localparam int TAP_NEWEST  = 8;
  localparam int PIXEL_W_DEF = 8;

  // Tap k lives at [k*PIXEL_W +: PIXEL_W]; tap 0 is top-left, tap 8 is newest.
  typedef logic [WIN_TAPS-1:0][PIXEL_W_DEF-1:0] window_t;
endpackage

// File: rtl/bram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// Contents and read register are not reset.
module bram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its output while re is low
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/line_buffer_3x3.sv
// Streaming 3x3 window generator. Two line BRAMs hold lines y-1 (lineA) and
// y-2 (lineB); a 3x3 register window shifts left on every stage-2 advance.
// Optional line-format checking is built when LB_LINE_CHECK_EN is defined.
module line_buffer_3x3
  import median_filter_pkg::*;
#(
  parameter int PIXEL_W = 8,
  parameter int IMG_W   = 640
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid_i,
  output logic                        s_ready_o,
  input  logic [PIXEL_W-1:0]          s_data_i,
  input  logic                        s_sof_i,
  input  logic                        s_eol_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [WIN_TAPS*PIXEL_W-1:0] m_window_o,
  output logic                        m_eol_o,
  output logic                        err_o
);
  localparam int               COL_W    = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W-1);

  logic                               adv, acc, stg2, line_end;
  logic [COL_W-1:0]                   col, col_eff, s1_col;
  logic [1:0]                         row, row_eff;
  logic                               s1_vld, s1_eol, s1_qual;
  logic [PIXEL_W-1:0]                 s1_pix, rd_a, rd_b;
  logic [WIN_TAPS-1:0][PIXEL_W-1:0]   win;

  // Whole pipeline moves only when the output slot is free or being taken
  assign adv       = !m_valid_o || m_ready_i;
  assign s_ready_o = adv;
  assign acc       = s_valid_i && adv;
  assign stg2      = s1_vld && adv;

  // SOF forces the pixel to the frame origin, discarding prior line state
  assign col_eff  = s_sof_i ? '0 : col;
  assign row_eff  = s_sof_i ? 2'd0 : row;
  assign line_end = s_eol_i || (col_eff == COL_LAST);

  // Column/row position of the next pixel; row saturates at 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (line_end) begin
        col <= '0;
        row <= (row_eff == 2'd2) ? 2'd2 : row_eff + 2'd1;
      end else begin
        col <= col_eff + 1'b1;
        row <= row_eff;
      end
    end
  end

  // Stage 1: capture the accepted pixel while the BRAMs read its column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_pix  <= '0;
      s1_col  <= '0;
      s1_eol  <= 1'b0;
      s1_qual <= 1'b0;
    end else if (adv) begin
      s1_vld <= acc;
      if (acc) begin
        s1_pix  <= s_data_i;
        s1_col  <= col_eff;
        s1_eol  <= line_end;
        s1_qual <= (row_eff == 2'd2) && (col_eff >= COL_W'(2));
      end
    end
  end

  // Stage 2: shift the window left and insert {lineB, lineA, pixel} on the right
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= '0;
      m_valid_o <= 1'b0;
      m_eol_o   <= 1'b0;
    end else if (stg2) begin
      for (int r = 0; r < WIN_DIM; r++)
        for (int c = 0; c < WIN_DIM-1; c++)
          win[r*WIN_DIM+c] <= win[r*WIN_DIM+c+1];
      win[WIN_DIM-1]   <= rd_b;
      win[2*WIN_DIM-1] <= rd_a;
      win[TAP_NEWEST]  <= s1_pix;
      m_valid_o        <= s1_qual;
      m_eol_o          <= s1_eol;
    end else if (adv) begin
      m_valid_o <= 1'b0;
    end
  end

  assign m_window_o = win;

  // lineA takes the new pixel; lineB takes what lineA held at that column
  bram #(.DATA_W(PIXEL_W), .ADDR_W(COL_W)) u_line_a (
    .clk   (clk),
    .we    (stg2),
    .waddr (s1_col),
    .wdata (s1_pix),
    .re    (acc),
    .raddr (col_eff),
    .rdata (rd_a)
  );

  bram #(.DATA_W(PIXEL_W), .ADDR_W(COL_W)) u_line_b (
    .clk   (clk),
    .we    (stg2),
    .waddr (s1_col),
    .wdata (rd_a),
    .re    (acc),
    .raddr (col_eff),
    .rdata (rd_b)
  );

`ifdef LB_LINE_CHECK_EN
  // Sticky format error: wrap without EOL, or EOL on a line too short for a window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_o <= 1'b0;
    end else if (acc) begin
      err_o <= (err_o && !s_sof_i)
             || ((col_eff == COL_LAST) && !s_eol_i)
             || (s_eol_i && (col_eff < COL_W'(2)));
    end
  end
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_line_buffer_3x3.sv
// Scoreboard bench for line_buffer_3x3 with IMG_W=4 and pixel = row*16+col.
module tb_line_buffer_3x3;
  localparam int PW = 8;
  localparam int IW = 4;
  localparam int WW = 9*PW;
`ifdef LB_LINE_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0, m_ready = 1'b1;
  logic [PW-1:0] s_data = '0;
  logic          s_ready, m_valid, m_eol, err;
  logic [WW-1:0] m_window;

  always #5 clk = ~clk;

  line_buffer_3x3 #(.PIXEL_W(PW), .IMG_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
    .s_sof_i(s_sof), .s_eol_i(s_eol),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_window_o(m_window),
    .m_eol_o(m_eol), .err_o(err)
  );

  typedef struct packed {logic [WW-1:0] w; logic eol;} exp_t;
  exp_t sb[$];

  int errors = 0, checks = 0, n_pop = 0, cyc = 0;
  bit track = 1'b0, got_first = 1'b0, rnd_done = 1'b0;
  int vld_cyc = -1;
  logic [WW-1:0] first_w = '0, last_w = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [PW-1:0] pix(input int r, input int c);
    return 8'(r*16 + c);
  endfunction

  function automatic logic [WW-1:0] win_at(input int r, input int c);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*PW +: PW] = pix(r-2+k/3, c-2+k%3);
    return w;
  endfunction

  // Monitor: a window is taken at the posedge following a negedge with valid&&ready
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (track && m_valid && vld_cyc < 0) vld_cyc = cyc;
      if (m_valid && m_ready) begin
        if (!got_first) first_w = m_window;
        got_first = 1'b1;
        last_w = m_window;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_window: got %h expected none", m_window);
        end else begin
          e = sb.pop_front();
          chk("window", m_window, e.w);
          chk("eol", WW'(m_eol), WW'(e.eol));
          n_pop++;
        end
      end
    end
  end

  task automatic send(input logic [PW-1:0] d, input logic sof, input logic eol,
                      input bit push, input logic [WW-1:0] w, input logic weol, output int at);
    int n = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    @(negedge clk);
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    at = cyc;
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got ready=0 expected ready=1");
    end else if (push) sb.push_back('{w: w, eol: weol});
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, output int acc22);
    int a;
    acc22 = -1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        send(pix(r, c), (r == 0 && c == 0), (c == 3), (r >= 2 && c >= 2), win_at(r, c), (c == 3), a);
        if (r == 2 && c == 2) acc22 = a;
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      end
  endtask

  task automatic drain();
    int n = 0;
    m_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_empty", WW'(sb.size()), '0);
  endtask

  initial begin
    int a, acc22, n0, n;
    logic [WW-1:0] cap;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", WW'(m_valid), '0);
    chk("rst_window", m_window, '0);
    chk("rst_eol", WW'(m_eol), '0);
    chk("rst_err", WW'(err), '0);
    chk("rst_s_ready", WW'(s_ready), WW'(1));
    @(posedge clk); #1;

    // Basic 4x4 frame
    n0 = n_pop; track = 1'b1; got_first = 1'b0;
    send_frame(0, acc22);
    drain();
    track = 1'b0;
    chk("latency", WW'(vld_cyc - acc22), WW'(2));
    chk("basic_count", WW'(n_pop - n0), WW'(4));
    chk("first_window", first_w, 72'h22_21_20_12_11_10_02_01_00);
    chk("last_window", last_w, 72'h33_32_31_23_22_21_13_12_11);

    // Backpressure for 5 cycles on the first window
    n0 = n_pop;
    fork
      send_frame(0, a);
      begin
        n = 0;
        @(posedge clk); #1;
        while (!m_valid && n < 100) begin @(posedge clk); #1; n++; end
        if (!m_valid) begin
          checks++; errors++;
          $display("FAIL bp_wait: got valid=0 expected valid=1");
        end else begin
          m_ready = 1'b0;
          cap = m_window;
          repeat (5) begin
            @(negedge clk);
            chk("bp_s_ready", WW'(s_ready), '0);
            chk("bp_valid", WW'(m_valid), WW'(1));
            chk("bp_frozen", m_window, cap);
          end
          @(posedge clk); #1 m_ready = 1'b1;
        end
      end
    join
    drain();
    chk("bp_count", WW'(n_pop - n0), WW'(4));

    // Random input gaps and random downstream ready, two frames
    n0 = n_pop; rnd_done = 1'b0;
    fork
      begin
        send_frame(3, a);
        send_frame(2, a);
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1));
      end
    join
    drain();
    chk("rand_count", WW'(n_pop - n0), WW'(8));

    // SOF after 1.5 lines of marked (0x80) pixels
    n0 = n_pop;
    for (int i = 0; i < 6; i++)
      send(8'h80 | pix(i/4, i%4), (i == 0), (i == 3), 1'b0, '0, 1'b0, a);
    send_frame(0, a);
    drain();
    chk("sof_count", WW'(n_pop - n0), WW'(4));

    // Reset during row 3 with a window held at the output
    for (int i = 0; i < 15; i++) begin
      send(pix(i/4, i%4), (i == 0), (i%4 == 3), (i/4 >= 2 && i%4 >= 2), win_at(i/4, i%4), (i%4 == 3), a);
      if (i == 14) m_ready = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_valid", WW'(m_valid), WW'(1));
    chk("hold_window", m_window, win_at(3, 2));
    chk("pending", WW'(sb.size()), WW'(1));
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", WW'(m_valid), '0);
    chk("midrst_window", m_window, '0);
    chk("midrst_s_ready", WW'(s_ready), WW'(1));
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1; m_ready = 1'b1;
    n0 = n_pop; got_first = 1'b0;
    send_frame(0, a);
    drain();
    chk("rst_count", WW'(n_pop - n0), WW'(4));
    chk("rst_first", first_w, 72'h22_21_20_12_11_10_02_01_00);

    // Line checks: short line, then implicit wraps
    send(8'h00, 1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    send(8'h01, 1'b0, 1'b1, 1'b0, '0, 1'b0, a);
    chk("err_short", WW'(err), WW'(CHK));
    send(8'h10, 1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    send(8'h11, 1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    chk("err_held", WW'(err), WW'(CHK));
    send(8'h00, 1'b1, 1'b0, 1'b0, '0, 1'b0, a);
    chk("err_clear", WW'(err), '0);
    for (int i = 1; i < 8; i++) send(pix(i/4, i%4), 1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    chk("err_wrap", WW'(err), WW'(CHK));
    n0 = n_pop;
    send(8'h20, 1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    send(8'h21, 1'b0, 1'b0, 1'b0, '0, 1'b0, a);
    send(8'h22, 1'b0, 1'b0, 1'b1, win_at(2, 2), 1'b0, a);
    drain();
    chk("wrap_count", WW'(n_pop - n0), WW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
